mmio_bus_ctrl: RTL

- Data-side bus controller directly downstream of the single-cycle CPU core; consumes its mem_write/mem_addr/write_data bus and returns read_data.
- Routes word accesses to the external data RAM or to memory-mapped peripheral registers: LEDs, switches, buttons, cycle counter and UART transmitter.
- The UART transmitter includes a TX FIFO and an 8N1 serializer.
- Reads are combinational, so the core completes every load in one cycle; all state updates happen on the rising clock edge.

---
 rtl/mmio_bus_ctrl_pkg.sv | 50 +++++
 rtl/mmio_bus_ctrl_if.sv | 33 +++
 rtl/mmio_bus_ctrl_uart_tx_fifo.sv | 176 +++++++++++++++++
 rtl/mmio_bus_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/mmio_bus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_pkg
//  Description : Shared constants and types for the MMIO bus controller:
//                register offsets, STATUS bit positions, UART FSM state type
//                and a helper that packs the STATUS word.
//  Revision    : 1.0  initial release
// ============================================================================
package mmio_pkg;

    localparam int c_WORD_W = 32;

    // Register offsets inside the peripheral block (mem_addr[7:0])
    localparam logic [7:0] c_REG_LED    = 8'h00;
    localparam logic [7:0] c_REG_SW     = 8'h04;
    localparam logic [7:0] c_REG_BTN    = 8'h08;
    localparam logic [7:0] c_REG_CYCLE  = 8'h0C;
    localparam logic [7:0] c_REG_TXDATA = 8'h10;
    localparam logic [7:0] c_REG_STATUS = 8'h14;

    // STATUS register bit positions
    localparam int c_ST_EMPTY = 0;
    localparam int c_ST_FULL  = 1;
    localparam int c_ST_BUSY  = 2;
    localparam int c_ST_OVF   = 3;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

    function automatic logic [c_WORD_W-1:0] status_word(
        input logic ovf,
        input logic busy,
        input logic full,
        input logic empty
    );
        logic [c_WORD_W-1:0] w;
        w             = '0;
        w[c_ST_OVF]   = ovf;
        w[c_ST_BUSY]  = busy;
        w[c_ST_FULL]  = full;
        w[c_ST_EMPTY] = empty;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_bus_ctrl_if
//  Description : CPU data-side bus. The core (master) drives the store
//                strobe, byte address and store data; the controller (slave)
//                returns combinational load data in the same cycle.
//  Ports       : mem_write, mem_addr[31:0], write_data[31:0], read_data[31:0]
//  Revision    : 1.0  initial release
// ============================================================================
interface mmio_bus_ctrl_if;
    import mmio_pkg::*;

    logic                mem_write;
    logic [c_WORD_W-1:0] mem_addr;
    logic [c_WORD_W-1:0] write_data;
    logic [c_WORD_W-1:0] read_data;

    modport master (
        output mem_write,
        output mem_addr,
        output write_data,
        input  read_data
    );

    modport slave (
        input  mem_write,
        input  mem_addr,
        input  write_data,
        output read_data
    );

endinterface
`default_nettype wire

// File: rtl/mmio_bus_ctrl_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : UART transmitter: byte FIFO feeding an 8N1 serializer.
//                A push on a full FIFO is dropped and sets a sticky overflow
//                flag. Frames go out back-to-back: the end of STOP pops the
//                next byte directly, without an idle cycle.
//  Ports       : clk, rst            clock / synchronous active-high reset
//                push, din[7:0]      enqueue request and byte
//                clr_overflow        clears the sticky overflow flag
//                full, empty         FIFO status
//                overflow, busy      sticky drop flag / serializer active
//                tx                  registered serial line, idle high
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_fifo
    import mmio_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,   // power of two, >= 2
    parameter int CLKS_PER_BIT = 868
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       push,
    input  wire logic [7:0] din,
    input  wire logic       clr_overflow,
    output logic            full,
    output logic            empty,
    output logic            overflow,
    output logic            busy,
    output logic            tx
);

    localparam int c_AW     = $clog2(FIFO_DEPTH);
    localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] c_S_IDLE  = UART_IDLE;
    localparam logic [1:0] c_S_START = UART_START;
    localparam logic [1:0] c_S_DATA  = UART_DATA;
    localparam logic [1:0] c_S_STOP  = UART_STOP;

    // ---------------------------------------------------------------- FIFO
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [c_AW:0] r_wr_ptr;
    logic [c_AW:0] r_rd_ptr;
    logic          r_overflow;
    logic          w_push_ok;
    logic          w_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

    // Full is judged before any same-edge pop, so a push racing a pop on a
    // full FIFO is still dropped.
    assign w_push_ok = push && !full;
    assign overflow  = r_overflow;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (clr_overflow) begin
                r_overflow <= 1'b0;
            end else if (push && full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------- serializer
    logic [1:0]          r_state;
    logic [c_BAUD_W-1:0] r_baud;
    logic [2:0]          r_bitcnt;
    logic [7:0]          r_shift;
    logic                r_tx;
    logic                w_baud_done;
    logic [7:0]          w_head;

    assign w_baud_done = (r_baud == c_BAUD_LAST);
    assign w_head      = r_mem[r_rd_ptr[c_AW-1:0]];

    // Pop from IDLE, or straight out of a finishing STOP bit.
    assign w_pop = !empty &&
                   ((r_state == c_S_IDLE) ||
                    ((r_state == c_S_STOP) && w_baud_done));

    assign busy = (r_state != c_S_IDLE);
    assign tx   = r_tx;

    // r_tx is loaded with the level of the state being entered, so the line
    // changes on the same edge as the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_S_IDLE;
            r_baud   <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    r_tx <= 1'b1;
                    if (!empty) begin
                        r_shift <= w_head;
                        r_baud  <= '0;
                        r_state <= c_S_START;
                        r_tx    <= 1'b0;
                    end
                end
                c_S_START: begin
                    if (w_baud_done) begin
                        r_baud   <= '0;
                        r_bitcnt <= '0;
                        r_state  <= c_S_DATA;
                        r_tx     <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                c_S_DATA: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_bitcnt == 3'd7) begin
                            r_state <= c_S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_tx     <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                c_S_STOP: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (!empty) begin
                            r_shift <= w_head;
                            r_state <= c_S_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= c_S_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mmio_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_bus_ctrl
//  Description : Data-side bus controller for a single-cycle CPU. Decodes
//                word accesses to the external data RAM window or to the
//                peripheral register block (LED, SW, BTN, CYCLE, TXDATA,
//                STATUS). Loads are combinational; state updates on clk.
//  Ports       : clk, rst                  clock / sync active-high reset
//                bus (slave)               CPU store/load bus
//                ram_we/addr/wdata, rdata  external data RAM
//                switches, buttons         asynchronous board inputs
//                leds                      registered LED outputs
//                uart_tx                   serial output, idle high
//  Revision    : 1.0  initial release
// ============================================================================
module mmio_bus_ctrl
    import mmio_pkg::*;
#(
    parameter logic [31:0] DATA_BASE    = 32'h1001_0000,
    parameter int          RAM_AW       = 12,
    parameter logic [31:0] MMIO_BASE    = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH   = 16,
    parameter int          CLKS_PER_BIT = 868
) (
    input  wire logic              clk,
    input  wire logic              rst,
    mmio_bus_ctrl_if.slave         bus,
    output logic                   ram_we,
    output logic [RAM_AW-1:0]      ram_addr,
    output logic [31:0]            ram_wdata,
    input  wire logic [31:0]       ram_rdata,
    input  wire logic [15:0]       switches,
    input  wire logic [4:0]        buttons,
    output logic [15:0]            leds,
    output logic                   uart_tx
);

    // One past the last RAM byte, kept 33 bits wide so a window ending at
    // the top of the address space still compares correctly.
    localparam logic [32:0] c_RAM_END = {1'b0, DATA_BASE} + (33'd4 << RAM_AW);

    // ------------------------------------------------------------- decode
    logic       w_ram_sel;
    logic       w_mmio_sel;
    logic [7:0] w_off;
    logic       w_mmio_wr;
    logic       w_led_we;
    logic       w_cycle_we;
    logic       w_tx_push;
    logic       w_status_we;

    assign w_ram_sel  = (bus.mem_addr >= DATA_BASE) &&
                        ({1'b0, bus.mem_addr} < c_RAM_END);
    assign w_mmio_sel = (bus.mem_addr[31:8] == MMIO_BASE[31:8]);
    assign w_off      = bus.mem_addr[7:0];
    assign w_mmio_wr  = bus.mem_write && w_mmio_sel;

    assign w_led_we    = w_mmio_wr && (w_off == c_REG_LED);
    assign w_cycle_we  = w_mmio_wr && (w_off == c_REG_CYCLE);
    assign w_tx_push   = w_mmio_wr && (w_off == c_REG_TXDATA);
    assign w_status_we = w_mmio_wr && (w_off == c_REG_STATUS);

    assign ram_we    = bus.mem_write && w_ram_sel;
    assign ram_addr  = bus.mem_addr[RAM_AW+1:2];
    assign ram_wdata = bus.write_data;

    // ---------------------------------------------------------- registers
    logic [31:0] r_led;
    logic [31:0] r_cycle;
    logic [15:0] r_sw_meta;
    logic [15:0] r_sw_sync;
    logic [4:0]  r_btn_meta;
    logic [4:0]  r_btn_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led      <= '0;
            r_cycle    <= '0;
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_btn_meta <= '0;
            r_btn_sync <= '0;
        end else begin
            if (w_led_we) begin
                r_led <= bus.write_data;
            end
            // A CPU write takes priority over the free-running increment.
            if (w_cycle_we) begin
                r_cycle <= '0;
            end else begin
                r_cycle <= r_cycle + 32'd1;
            end
            r_sw_meta  <= switches;
            r_sw_sync  <= r_sw_meta;
            r_btn_meta <= buttons;
            r_btn_sync <= r_btn_meta;
        end
    end

    assign leds = r_led[15:0];

    // --------------------------------------------------------------- UART
    logic w_full;
    logic w_empty;
    logic w_overflow;
    logic w_busy;

    uart_tx_fifo #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx_fifo (
        .clk          (clk),
        .rst          (rst),
        .push         (w_tx_push),
        .din          (bus.write_data[7:0]),
        .clr_overflow (w_status_we),
        .full         (w_full),
        .empty        (w_empty),
        .overflow     (w_overflow),
        .busy         (w_busy),
        .tx           (uart_tx)
    );

    // ---------------------------------------------------------- load mux
    always_comb begin
        bus.read_data = '0;
        if (w_ram_sel) begin
            bus.read_data = ram_rdata;
        end else if (w_mmio_sel) begin
            case (w_off)
                c_REG_LED:    bus.read_data = r_led;
                c_REG_SW:     bus.read_data = {16'b0, r_sw_sync};
                c_REG_BTN:    bus.read_data = {27'b0, r_btn_sync};
                c_REG_CYCLE:  bus.read_data = r_cycle;
                c_REG_STATUS: bus.read_data = status_word(w_overflow, w_busy,
                                                          w_full, w_empty);
                default:      bus.read_data = '0;
            endcase
        end
    end

endmodule
`default_nettype wire
